// File: rtl/keypad_scan_encoder.sv
// keypad_scan_encoder
// -------------------
// Scans a 4x4 active-low matrix keypad one row per scan strobe, debounces
// whole frames, and offers one encoded key to a consumer.
//
// Handshake: key_valid/pressed_index are raised together and held stable
// until a clk edge sees key_valid && key_ready (the transfer). key_ready
// while key_valid is low has no effect. Dropping en or asserting rst
// withdraws a pending offer without a transfer.
//
// Optional build macro: KB_AUTO_REPEAT_EN. When defined, a key that stays
// pressed after delivery is re-offered every REPEAT_FRAMES frames.
//
// Ports
//   clk            system clock (only clock)
//   rst            synchronous, active-high reset
//   scan_clk       slow scan strobe, synchronized; its rising edge = scan_step
//   en             scan enable; low forces IDLE and drops any pending offer
//   keyboard_row   row drive, active-low one-hot (1111 when idle)
//   keyboard_col   column sense, active-low, synchronized
//   pressed_index  encoded key {row[1:0], col[1:0]}
//   key_valid      offer valid
//   key_ready      consumer ready
//   dbg_state      current FSM state (IDLE=0, SCAN=1, OFFER=2, HOLD=3)
//
// Parameters
//   DEBOUNCE_FRAMES  identical frames to accept a press or release (1..15)
//   REPEAT_FRAMES    frames between auto-repeat offers (macro build only)
//
// Timing note: columns pass through a 2-flop synchronizer, so the scan
// strobe period must leave at least 3 clk cycles between a row change and
// the next scan_step for the sample to reflect the new row.

module keypad_scan_encoder #(
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int REPEAT_FRAMES   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_clk,
  input  logic       en,
  output logic [3:0] keyboard_row,
  input  logic [3:0] keyboard_col,
  output logic [3:0] pressed_index,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [1:0] dbg_state
);

  // Counter wide enough for both the debounce limit (<=15) and the repeat
  // interval, so both counters share one width.
  localparam int REP_W = $clog2(REPEAT_FRAMES + 1);
  localparam int CNT_W = (REP_W > 4) ? REP_W : 4;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
`ifdef KB_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_FRAMES);
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_OFFER = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // Synchronizers and strobe edge detect
  logic       r_scan_meta, r_scan_sync, r_scan_prev;
  logic [3:0] r_col_meta, r_col_sync;

  // State
  state_t           r_state, w_state_nxt;
  logic [1:0]       r_row, w_row_nxt;
  logic [1:0]       r_acc, w_acc_nxt;         // keys seen this frame: 0, 1, 2=many
  logic [3:0]       r_acc_key, w_acc_key_nxt; // first key seen this frame
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_cand, w_cand_nxt;       // key being debounced in SCAN
  logic [3:0]       r_index, w_index_nxt;
  logic             r_valid, w_valid_nxt;
`ifdef KB_AUTO_REPEAT_EN
  logic [CNT_W-1:0] r_rep, w_rep_nxt;
  logic [CNT_W-1:0] w_rep_inc;
`endif

  // Combinational helpers
  logic             w_scan_step;
  logic [3:0]       w_col_low;
  logic             w_row_single;
  logic [1:0]       w_col_enc;
  logic [1:0]       w_acc_sum;
  logic [3:0]       w_acc_key_sum;
  logic             w_frame_end;
  logic             w_frame_none;
  logic             w_frame_single;
  logic             w_xfer;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_run;

  assign w_scan_step    = r_scan_sync & ~r_scan_prev;
  assign w_col_low      = ~r_col_sync;
  assign w_frame_end    = w_scan_step && (r_row == 2'd3) && (r_state != ST_IDLE);
  assign w_frame_none   = (w_acc_sum == 2'd0);
  assign w_frame_single = (w_acc_sum == 2'd1);
  assign w_xfer         = r_valid && key_ready;
  assign w_cnt_inc      = r_cnt + CNT_ONE;
`ifdef KB_AUTO_REPEAT_EN
  assign w_rep_inc      = r_rep + CNT_ONE;
`endif

  // One-hot detect and encode of the columns pulled low in the current row.
  always_comb begin
    w_row_single = 1'b0;
    w_col_enc    = 2'd0;
    case (w_col_low)
      4'b0001: begin w_row_single = 1'b1; w_col_enc = 2'd0; end
      4'b0010: begin w_row_single = 1'b1; w_col_enc = 2'd1; end
      4'b0100: begin w_row_single = 1'b1; w_col_enc = 2'd2; end
      4'b1000: begin w_row_single = 1'b1; w_col_enc = 2'd3; end
      default: begin w_row_single = 1'b0; w_col_enc = 2'd0; end
    endcase
  end

  // Frame accumulator including the row being sampled now; at row 3 this
  // is the complete frame result.
  always_comb begin
    w_acc_sum     = r_acc;
    w_acc_key_sum = r_acc_key;
    if (w_col_low != 4'b0000) begin
      if (w_row_single && (r_acc == 2'd0)) begin
        w_acc_sum     = 2'd1;
        w_acc_key_sum = {r_row, w_col_enc};
      end else begin
        w_acc_sum = 2'd2;
      end
    end
  end

  // Next-state and datapath
  always_comb begin
    w_state_nxt   = r_state;
    w_row_nxt     = r_row;
    w_acc_nxt     = r_acc;
    w_acc_key_nxt = r_acc_key;
    w_cnt_nxt     = r_cnt;
    w_cand_nxt    = r_cand;
    w_index_nxt   = r_index;
    w_valid_nxt   = r_valid;
    w_run         = CNT_ONE;
`ifdef KB_AUTO_REPEAT_EN
    w_rep_nxt     = r_rep;
`endif

    if (!en) begin
      w_state_nxt   = ST_IDLE;
      w_row_nxt     = 2'd0;
      w_acc_nxt     = 2'd0;
      w_acc_key_nxt = 4'd0;
      w_cnt_nxt     = '0;
      w_cand_nxt    = 4'd0;
      w_valid_nxt   = 1'b0;
`ifdef KB_AUTO_REPEAT_EN
      w_rep_nxt     = '0;
`endif
    end else begin
      // Row scanning runs in every active state, including OFFER.
      if ((r_state != ST_IDLE) && w_scan_step) begin
        w_row_nxt = r_row + 2'd1;
        if (w_frame_end) begin
          w_acc_nxt     = 2'd0;
          w_acc_key_nxt = 4'd0;
        end else begin
          w_acc_nxt     = w_acc_sum;
          w_acc_key_nxt = w_acc_key_sum;
        end
      end

      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_SCAN;
        end

        ST_SCAN: begin
          if (w_frame_end) begin
            if (w_frame_single) begin
              // Same key as last frame extends the run, otherwise restart at 1.
              if ((r_cnt != '0) && (w_acc_key_sum == r_cand)) w_run = w_cnt_inc;
              else                                            w_run = CNT_ONE;
              w_cand_nxt = w_acc_key_sum;
              if (w_run == DB_LAST) begin
                w_index_nxt = w_acc_key_sum;
                w_valid_nxt = 1'b1;
                w_state_nxt = ST_OFFER;
                w_cnt_nxt   = '0;
              end else begin
                w_cnt_nxt = w_run;
              end
            end else begin
              w_cnt_nxt = '0;
            end
          end
        end

        ST_OFFER: begin
          if (w_xfer) begin
            w_valid_nxt = 1'b0;
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = '0;
`ifdef KB_AUTO_REPEAT_EN
            w_rep_nxt   = '0;
`endif
          end
        end

        ST_HOLD: begin
          if (w_frame_end) begin
            if (w_frame_none) begin
`ifdef KB_AUTO_REPEAT_EN
              w_rep_nxt = '0;
`endif
              if (w_cnt_inc == DB_LAST) begin
                w_state_nxt = ST_SCAN;
                w_cnt_nxt   = '0;
              end else begin
                w_cnt_nxt = w_cnt_inc;
              end
            end else begin
              w_cnt_nxt = '0;
`ifdef KB_AUTO_REPEAT_EN
              // Only the key that was delivered keeps the repeat timer running.
              if (w_frame_single && (w_acc_key_sum == r_index)) begin
                if (w_rep_inc == RP_LAST) begin
                  w_valid_nxt = 1'b1;
                  w_state_nxt = ST_OFFER;
                  w_rep_nxt   = '0;
                end else begin
                  w_rep_nxt = w_rep_inc;
                end
              end else begin
                w_rep_nxt = '0;
              end
`endif
            end
          end
        end

        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_meta <= 1'b0;
      r_scan_sync <= 1'b0;
      r_scan_prev <= 1'b0;
      r_col_meta  <= 4'b1111;
      r_col_sync  <= 4'b1111;
      r_state     <= ST_IDLE;
      r_row       <= 2'd0;
      r_acc       <= 2'd0;
      r_acc_key   <= 4'd0;
      r_cnt       <= '0;
      r_cand      <= 4'd0;
      r_index     <= 4'd0;
      r_valid     <= 1'b0;
`ifdef KB_AUTO_REPEAT_EN
      r_rep       <= '0;
`endif
    end else begin
      r_scan_meta <= scan_clk;
      r_scan_sync <= r_scan_meta;
      r_scan_prev <= r_scan_sync;
      r_col_meta  <= keyboard_col;
      r_col_sync  <= r_col_meta;
      r_state     <= w_state_nxt;
      r_row       <= w_row_nxt;
      r_acc       <= w_acc_nxt;
      r_acc_key   <= w_acc_key_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cand      <= w_cand_nxt;
      r_index     <= w_index_nxt;
      r_valid     <= w_valid_nxt;
`ifdef KB_AUTO_REPEAT_EN
      r_rep       <= w_rep_nxt;
`endif
    end
  end

  assign keyboard_row  = (r_state == ST_IDLE) ? 4'b1111 : ~(4'b0001 << r_row);
  assign pressed_index = r_index;
  assign key_valid     = r_valid;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Bench for keypad_scan_encoder: a keypad model answers the row drive,
// directed key sequences push expected indices into exp_q, and a monitor
// pops and compares on every transfer. Frame ends are recognised from the
// row drive going from row 3 to row 0.
module tb_keypad_scan_encoder;

  localparam int DEB = 3;
  localparam int REP = 4;
`ifdef KB_AUTO_REPEAT_EN
  localparam int HELD_OFFERS = 5;   // offers at frames 3,7,11,15,19 of 20
`else
  localparam int HELD_OFFERS = 1;
`endif

  logic       clk;
  logic       rst;
  logic       scan_clk;
  logic       en;
  logic [3:0] keyboard_row;
  logic [3:0] keyboard_col;
  logic [3:0] pressed_index;
  logic       key_valid;
  logic       key_ready;
  logic [1:0] dbg_state;

  logic [15:0] keys;           // pressed keys, bit {r,c}
  int          ready_mode;     // 0 = low, 1 = key_valid delayed 1 clk, 2 = high
  int          checks = 0;
  int          errors = 0;
  int          frame_cnt = 0;
  int          rise_cnt = 0;
  int          xfer_cnt = 0;
  int          last_rise_frame = -1;
  logic        last_rise_edge = 1'b0;
  logic [3:0]  exp_q[$];

  keypad_scan_encoder #(
    .DEBOUNCE_FRAMES(DEB),
    .REPEAT_FRAMES  (REP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .scan_clk     (scan_clk),
    .en           (en),
    .keyboard_row (keyboard_row),
    .keyboard_col (keyboard_col),
    .pressed_index(pressed_index),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset block ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scan strobe: 16 clk period
  initial begin
    scan_clk = 1'b0;
    forever begin
      repeat (8) @(negedge clk);
      scan_clk = ~scan_clk;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Keypad matrix model
  always_comb begin
    keyboard_col = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!keyboard_row[r] && keys[r*4+c]) keyboard_col[c] = 1'b0;
  end

  // Consumer ready driver
  initial begin
    logic last_valid;
    last_valid = 1'b0;
    key_ready  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       key_ready = last_valid;
        2:       key_ready = 1'b1;
        default: key_ready = 1'b0;
      endcase
      last_valid = (key_valid === 1'b1);
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [3:0] prev_row;
    logic       prev_valid;
    logic       edge_now;
    logic [3:0] e;
    prev_row   = 4'b1111;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      edge_now = (prev_row == 4'b0111) && (keyboard_row == 4'b1110);
      if (edge_now) frame_cnt++;
      if ((key_valid === 1'b1) && !prev_valid) begin
        rise_cnt++;
        last_rise_frame = frame_cnt;
        last_rise_edge  = edge_now;
      end
      if ((key_valid === 1'b1) && (key_ready === 1'b1)) begin
        xfer_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL xfer_unexpected: got index %0d, expected no transfer", pressed_index);
        end else begin
          e = exp_q.pop_front();
          if (pressed_index !== e) begin
            errors++;
            $display("FAIL xfer_index: got %0d expected %0d", pressed_index, e);
          end
        end
      end
      prev_row   = keyboard_row;
      prev_valid = (key_valid === 1'b1);
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Wait until frame_cnt reaches target; returns just after a posedge.
  task automatic wait_frame(input int target);
    int budget;
    budget = (target - frame_cnt + 1) * 128;
    if (budget < 128) budget = 128;
    while ((frame_cnt < target) && (budget > 0)) begin
      @(posedge clk);
      budget--;
    end
    if (frame_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: got frame %0d expected %0d", frame_cnt, target);
    end
    #1;
  endtask

  // Align to the next frame boundary and return its frame number.
  task automatic next_boundary(output int f);
    wait_frame(frame_cnt + 1);
    f = frame_cnt;
  endtask

  task automatic push_n(input logic [3:0] k, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(k);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int f0;
    int r0;
    int x0;
    rst        = 1'b1;
    en         = 1'b0;
    keys       = 16'h0000;
    ready_mode = 0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_row",   keyboard_row, 4'b1111);
    check("rst_valid", key_valid, 1'b0);
    check("rst_index", pressed_index, 4'd0);
    check("rst_state", dbg_state, 2'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_row_en_low", keyboard_row, 4'b1111);
    en = 1'b1;
    @(negedge clk);
    check("scan_start_row0", keyboard_row, 4'b1110);
    wait_frame(frame_cnt + 2);

    // T1: key 5 steady for 20 frames, ready one cycle behind valid
    ready_mode = 1;
    next_boundary(f0);
    r0 = rise_cnt;
    x0 = xfer_cnt;
    keys = 16'h0001 << 5;
    push_n(4'd5, HELD_OFFERS);
    wait_frame(f0 + DEB);
    check("t1_first_rise_count", rise_cnt - r0, 1);
    check("t1_rise_frame", last_rise_frame - f0, DEB);
    check("t1_rise_on_frame_end", last_rise_edge, 1'b1);
    wait_frame(f0 + 20);
    check("t1_offers_in_20", rise_cnt - r0, HELD_OFFERS);
    check("t1_xfers_in_20", xfer_cnt - x0, HELD_OFFERS);
    check("t1_last_rise_frame", last_rise_frame - f0, DEB + REP * (HELD_OFFERS - 1));
    keys = 16'h0000;
    wait_frame(frame_cnt + 4);

    // T2: key 13 bounces: 2 pressed, 1 released, 3 pressed
    next_boundary(f0);
    r0 = rise_cnt;
    x0 = xfer_cnt;
    keys = 16'h0001 << 13;
    push_n(4'd13, 1);
    wait_frame(f0 + 2);
    keys = 16'h0000;
    wait_frame(f0 + 3);
    keys = 16'h0001 << 13;
    wait_frame(f0 + 6);
    check("t2_rise_count", rise_cnt - r0, 1);
    check("t2_rise_frame", last_rise_frame - f0, 6);
    wait_frame(f0 + 7);
    check("t2_xfer_count", xfer_cnt - x0, 1);
    keys = 16'h0000;
    wait_frame(frame_cnt + 4);

    // T3: keys 2 and 9 together for 10 frames, then 9 released
    next_boundary(f0);
    r0 = rise_cnt;
    keys = (16'h0001 << 2) | (16'h0001 << 9);
    wait_frame(f0 + 10);
    check("t3_multi_no_offer", rise_cnt - r0, 0);
    check("t3_multi_valid_low", key_valid, 1'b0);
    keys = 16'h0001 << 2;
    push_n(4'd2, 1);
    wait_frame(f0 + 13);
    check("t3_rise_frame", last_rise_frame - f0, 13);
    wait_frame(f0 + 14);
    keys = 16'h0000;
    wait_frame(frame_cnt + 4);

    // T4: offer of key 3 held 50 frames with ready low while key becomes 7
    ready_mode = 0;
    next_boundary(f0);
    r0 = rise_cnt;
    x0 = xfer_cnt;
    keys = 16'h0001 << 3;
    push_n(4'd3, 1);
    wait_frame(f0 + DEB);
    check("t4_rise_frame", last_rise_frame - f0, DEB);
    keys = 16'h0001 << 7;
    wait_frame(f0 + DEB + 50);
    check("t4_valid_held", key_valid, 1'b1);
    check("t4_index_held", pressed_index, 4'd3);
    check("t4_single_rise", rise_cnt - r0, 1);
    ready_mode = 1;
    repeat (6) @(negedge clk);
    check("t4_xfer_done", xfer_cnt - x0, 1);
    check("t4_valid_dropped", key_valid, 1'b0);
    wait_frame(frame_cnt + 8);
    check("t4_held7_not_emitted", rise_cnt - r0, 1);
    keys = 16'h0000;
    wait_frame(frame_cnt + 4);
    next_boundary(f0);
    keys = 16'h0001 << 7;
    push_n(4'd7, 1);
    wait_frame(f0 + DEB);
    check("t4_repress7_frame", last_rise_frame - f0, DEB);
    check("t4_repress7_count", rise_cnt - r0, 2);
    wait_frame(f0 + DEB + 1);
    keys = 16'h0000;
    wait_frame(frame_cnt + 4);

    // T5: en dropped during OFFER, then rst pulsed mid-SCAN
    ready_mode = 0;
    next_boundary(f0);
    r0 = rise_cnt;
    keys = 16'h0001 << 1;
    wait_frame(f0 + DEB);
    check("t5_offer_up", key_valid, 1'b1);
    repeat (3) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("t5_en_valid", key_valid, 1'b0);
    check("t5_en_row", keyboard_row, 4'b1111);
    check("t5_en_state", dbg_state, 2'd0);
    keys = 16'h0000;
    ready_mode = 2;
    repeat (10) @(negedge clk);
    en = 1'b1;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_valid", key_valid, 1'b0);
    check("t5_rst_row", keyboard_row, 4'b1111);
    rst = 1'b0;
    @(negedge clk);
    check("t5_resume_row0", keyboard_row, 4'b1110);
    check("t5_resume_state", dbg_state, 2'd1);
    r0 = rise_cnt;
    wait_frame(frame_cnt + 6);
    check("t5_no_stale_offer", rise_cnt - r0, 0);

    // T6: key 10 held 20 frames, ready always high
    next_boundary(f0);
    r0 = rise_cnt;
    x0 = xfer_cnt;
    keys = 16'h0001 << 10;
    push_n(4'd10, HELD_OFFERS);
    wait_frame(f0 + 20);
    check("t6_offers", rise_cnt - r0, HELD_OFFERS);
    check("t6_xfers", xfer_cnt - x0, HELD_OFFERS);
    check("t6_last_rise_frame", last_rise_frame - f0, DEB + REP * (HELD_OFFERS - 1));
    keys = 16'h0000;
    wait_frame(frame_cnt + 4);

    // ---------------- final report ----------------
    check("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
